// File: rtl/sort_sched_pkg.sv
// Shared types for the sort-engine scheduler: FSM state encoding and default data width.
package sort_pkg;

    typedef enum logic [1:0] {
        SS_IDLE,
        SS_FEED,
        SS_FLUSH,
        SS_DRAIN
    } sched_state_t;

    localparam int DW_DEF = 32;

endpackage

// File: rtl/sort_sched_rr_arbiter.sv
// Combinational round-robin arbiter: the lowest requesting index at or after ptr wins.
module rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt_onehot,
    output logic [IW-1:0] gnt_id
);

    int idx;

    always_comb begin
        // NOTE: every output gets a default before any branch, so no path can infer a latch.
        gnt_onehot = '0;
        gnt_id     = '0;
        idx        = 0;
        // Scan from the far end back towards ptr so the nearest requester is written last.
        for (int k = N - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % N;
            if (req[idx]) begin
                gnt_id = IW'(idx);
            end
        end
        if (|req) begin
            gnt_onehot = N'(1) << gnt_id;
        end
    end

endmodule

// File: rtl/sort_sched.sv
// Shares one sort engine among N_REQ AXI-Stream requesters, one whole packet at a time,
// returning each sorted result to its owner before re-arbitrating.
module sort_sched
    import sort_pkg::*;
#(
    parameter int N_REQ   = 2,
    parameter int MAX_LEN = 100,
    parameter int DW      = DW_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           s_tvalid,
    output logic [N_REQ-1:0]           s_tready,
    input  logic [N_REQ*DW-1:0]        s_tdata,
    input  logic [N_REQ-1:0]           s_tlast,
    output logic [N_REQ-1:0]           m_tvalid,
    input  logic [N_REQ-1:0]           m_tready,
    output logic [N_REQ*DW-1:0]        m_tdata,
    output logic [N_REQ-1:0]           m_tlast,
    output logic                       eng_in_tvalid,
    input  logic                       eng_in_tready,
    output logic [DW-1:0]              eng_in_tdata,
    output logic                       eng_in_tlast,
    input  logic                       eng_out_tvalid,
    output logic                       eng_out_tready,
    input  logic [DW-1:0]              eng_out_tdata,
    input  logic                       eng_out_tlast,
    output logic                       busy,
    output logic [$clog2(N_REQ)-1:0]   grant_id,
    output logic [N_REQ-1:0]           ovf_err
);

    localparam int IW = $clog2(N_REQ);
    localparam int CW = $clog2(MAX_LEN + 1);
    localparam logic [CW-1:0] LAST_BEAT = CW'(MAX_LEN - 1);

    sched_state_t   state, state_nxt;
    logic [IW-1:0]  rr_ptr;
    logic [IW-1:0]  arb_id;
    logic [N_REQ-1:0] arb_onehot;
    logic           arb_any;
    logic [CW-1:0]  beat_cnt;
    logic           at_limit;
    logic           s_valid_sel, s_last_sel, m_ready_sel;
    logic [DW-1:0]  s_data_sel;
    logic           in_hs, out_hs;

    rr_arbiter #(.N(N_REQ), .IW(IW)) u_arb (
        .req        (s_tvalid),
        .ptr        (rr_ptr),
        .gnt_onehot (arb_onehot),
        .gnt_id     (arb_id)
    );

    assign arb_any     = |arb_onehot;
    assign s_valid_sel = s_tvalid[grant_id];
    assign s_last_sel  = s_tlast[grant_id];
    assign s_data_sel  = s_tdata[grant_id*DW +: DW];
    assign m_ready_sel = m_tready[grant_id];
    assign at_limit    = (beat_cnt == LAST_BEAT);
    assign in_hs       = eng_in_tvalid && eng_in_tready;
    assign out_hs      = eng_out_tvalid && eng_out_tready;
    assign busy        = (state != SS_IDLE);

    // Handshake outputs are forced low while rst is high, even before the state register clears.
    always_comb begin
        state_nxt      = state;
        s_tready       = '0;
        m_tvalid       = '0;
        m_tlast        = '0;
        m_tdata        = '0;
        eng_in_tvalid  = 1'b0;
        eng_in_tdata   = s_data_sel;
        eng_in_tlast   = 1'b0;
        eng_out_tready = 1'b0;
        if (!rst) begin
            unique case (state)
                SS_IDLE: begin
                    if (arb_any) state_nxt = SS_FEED;
                end
                SS_FEED: begin
                    eng_in_tvalid      = s_valid_sel;
                    eng_in_tlast       = s_last_sel || at_limit;
                    s_tready[grant_id] = eng_in_tready;
                    if (s_valid_sel && eng_in_tready) begin
                        if (s_last_sel)    state_nxt = SS_DRAIN;
                        else if (at_limit) state_nxt = SS_FLUSH;
                    end
                end
                SS_FLUSH: begin
                    s_tready[grant_id] = 1'b1;
                    if (s_valid_sel && s_last_sel) state_nxt = SS_DRAIN;
                end
                SS_DRAIN: begin
                    m_tvalid[grant_id]         = eng_out_tvalid;
                    m_tlast[grant_id]          = eng_out_tlast;
                    m_tdata[grant_id*DW +: DW] = eng_out_tdata;
                    eng_out_tready             = m_ready_sel;
                    if (eng_out_tvalid && m_ready_sel && eng_out_tlast) state_nxt = SS_IDLE;
                end
                default: state_nxt = SS_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= SS_IDLE;
            grant_id <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
            ovf_err  <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register update based on pre-edge values.
            state <= state_nxt;
            case (state)
                SS_IDLE: begin
                    if (arb_any) begin
                        grant_id <= arb_id;
                        beat_cnt <= '0;
                    end
                end
                SS_FEED: begin
                    if (in_hs) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        if (!s_last_sel && at_limit) ovf_err[grant_id] <= 1'b1;
                    end
                end
                SS_DRAIN: begin
                    if (out_hs && eng_out_tlast) begin
                        rr_ptr <= (grant_id == IW'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sort_sched.sv
// Self-checking bench for sort_sched: requester, engine and consumer models plus an rr grant model.
module tb_sort_sched;
    import sort_pkg::*;

    localparam int N_REQ   = 3;
    localparam int MAX_LEN = 100;
    localparam int DW      = DW_DEF;
    localparam int IW      = $clog2(N_REQ);

    typedef logic [DW-1:0] word_t;
    typedef struct packed {
        logic  last;
        word_t data;
    } beat_t;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic [N_REQ-1:0]       s_tvalid, s_tready, s_tlast;
    logic [N_REQ*DW-1:0]    s_tdata;
    logic [N_REQ-1:0]       m_tvalid, m_tready, m_tlast;
    logic [N_REQ*DW-1:0]    m_tdata;
    logic                   eng_in_tvalid, eng_in_tready, eng_in_tlast;
    logic [DW-1:0]          eng_in_tdata;
    logic                   eng_out_tvalid, eng_out_tready, eng_out_tlast;
    logic [DW-1:0]          eng_out_tdata;
    logic                   busy;
    logic [IW-1:0]          grant_id;
    logic [N_REQ-1:0]       ovf_err;

    sort_sched #(.N_REQ(N_REQ), .MAX_LEN(MAX_LEN), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata), .s_tlast(s_tlast),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tlast(m_tlast),
        .eng_in_tvalid(eng_in_tvalid), .eng_in_tready(eng_in_tready),
        .eng_in_tdata(eng_in_tdata), .eng_in_tlast(eng_in_tlast),
        .eng_out_tvalid(eng_out_tvalid), .eng_out_tready(eng_out_tready),
        .eng_out_tdata(eng_out_tdata), .eng_out_tlast(eng_out_tlast),
        .busy(busy), .grant_id(grant_id), .ovf_err(ovf_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    beat_t            src_q [N_REQ][$];
    beat_t            exp_q [N_REQ][$];
    beat_t            eng_out_q [$];
    word_t            eng_buf [$];
    int               eng_len_log [$];
    int               grant_log [$];
    logic [N_REQ-1:0] exp_ovf;
    logic [N_REQ-1:0] idle_req;
    int               rr_model;
    logic             prev_busy;

    int gap_pct, ein_rdy_pct, eout_gap_pct, m_rdy_pct;
    bit m_toggle, chk_mirror;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: the result is the first MAX_LEN beats sorted ascending, last on the final one.
    task automatic add_pkt(input int r, input word_t d[$]);
        word_t kept[$];
        for (int k = 0; k < d.size(); k++) begin
            src_q[r].push_back('{last: (k == d.size() - 1), data: d[k]});
            if (k < MAX_LEN) kept.push_back(d[k]);
        end
        kept.sort();
        for (int k = 0; k < kept.size(); k++)
            exp_q[r].push_back('{last: (k == kept.size() - 1), data: kept[k]});
        if (d.size() > MAX_LEN) exp_ovf[r] = 1'b1;
    endtask

    task automatic add_rand_pkt(input int r, input int len);
        word_t d[$];
        for (int k = 0; k < len; k++) d.push_back($urandom);
        add_pkt(r, d);
    endtask

    task automatic drive();
        for (int r = 0; r < N_REQ; r++) begin
            if (rst || src_q[r].size() == 0) begin
                s_tvalid[r] = 1'b0;
                s_tlast[r]  = 1'b0;
            end else begin
                if (!s_tvalid[r]) s_tvalid[r] = ($urandom_range(99) >= gap_pct);
                s_tdata[r*DW +: DW] = src_q[r][0].data;
                s_tlast[r]          = src_q[r][0].last;
            end
            m_tready[r] = m_toggle ? ~m_tready[r] : ($urandom_range(99) < m_rdy_pct);
        end
        eng_in_tready = ($urandom_range(99) < ein_rdy_pct);
        if (rst || eng_out_q.size() == 0) begin
            eng_out_tvalid = 1'b0;
            eng_out_tlast  = 1'b0;
        end else begin
            if (!eng_out_tvalid) eng_out_tvalid = ($urandom_range(99) >= eout_gap_pct);
            eng_out_tdata = eng_out_q[0].data;
            eng_out_tlast = eng_out_q[0].last;
        end
    endtask

    // One clock: observe at the falling edge, update models and drive after the rising edge.
    task automatic step();
        logic [N_REQ-1:0] s_hs, m_hs;
        logic  ein_hs, eout_hs, ein_last;
        word_t ein_data;
        beat_t e;
        int    exp_g;
        @(negedge clk);
        s_hs     = s_tvalid & s_tready;
        m_hs     = m_tvalid & m_tready;
        ein_hs   = eng_in_tvalid && eng_in_tready;
        ein_last = eng_in_tlast;
        ein_data = eng_in_tdata;
        eout_hs  = eng_out_tvalid && eng_out_tready;
        if (rst) begin
            check("rst_s_tready", s_tready, 0);
            check("rst_m_tvalid", m_tvalid, 0);
            check("rst_m_tlast", m_tlast, 0);
            check("rst_eng_in_tvalid", eng_in_tvalid, 0);
            check("rst_eng_out_tready", eng_out_tready, 0);
        end else begin
            check("s_tready_onehot0", $onehot0(s_tready), 1);
            check("m_tvalid_onehot0", $onehot0(m_tvalid), 1);
            if (chk_mirror && eng_out_tvalid) check("eout_ready_mirror", eng_out_tready, m_tready[0]);
            for (int r = 0; r < N_REQ; r++) begin
                if (m_hs[r]) begin
                    check($sformatf("m%0d_beat_expected", r), exp_q[r].size() != 0, 1);
                    if (exp_q[r].size() != 0) begin
                        e = exp_q[r].pop_front();
                        check($sformatf("m%0d_tdata", r), m_tdata[r*DW +: DW], e.data);
                        check($sformatf("m%0d_tlast", r), m_tlast[r], e.last);
                    end
                end
            end
            if (busy && !prev_busy) begin
                exp_g = -1;
                for (int k = 0; k < N_REQ; k++) begin
                    int idx = (rr_model + k) % N_REQ;
                    if (exp_g < 0 && idle_req[idx]) exp_g = idx;
                end
                check("rr_grant", grant_id, exp_g);
                grant_log.push_back(int'(grant_id));
            end
            if (!busy && prev_busy && grant_log.size() != 0) rr_model = (grant_log[$] + 1) % N_REQ;
            if (!busy) idle_req = s_tvalid;
            prev_busy = busy;
        end
        @(posedge clk);
        #1;
        for (int r = 0; r < N_REQ; r++) begin
            if (s_hs[r] && src_q[r].size() != 0) begin
                void'(src_q[r].pop_front());
                s_tvalid[r] = 1'b0;
            end
        end
        if (ein_hs) begin
            eng_buf.push_back(ein_data);
            if (ein_last) begin
                eng_len_log.push_back(eng_buf.size());
                eng_buf.sort();
                for (int k = 0; k < eng_buf.size(); k++)
                    eng_out_q.push_back('{last: (k == eng_buf.size() - 1), data: eng_buf[k]});
                eng_buf.delete();
            end
        end
        if (eout_hs && eng_out_q.size() != 0) begin
            void'(eng_out_q.pop_front());
            eng_out_tvalid = 1'b0;
        end
        drive();
    endtask

    function automatic bit all_idle();
        bit idle = (busy === 1'b0) && (eng_out_q.size() == 0) && (eng_buf.size() == 0);
        for (int r = 0; r < N_REQ; r++)
            if (src_q[r].size() != 0 || exp_q[r].size() != 0) idle = 1'b0;
        return idle;
    endfunction

    task automatic run_until_done(input string tag, input int budget);
        int n = 0;
        drive();
        while (!all_idle() && n < budget) begin
            step();
            n++;
        end
        check({tag, "_complete"}, all_idle(), 1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        for (int r = 0; r < N_REQ; r++) begin
            src_q[r].delete();
            exp_q[r].delete();
        end
        eng_out_q.delete();
        eng_buf.delete();
        grant_log.delete();
        exp_ovf   = '0;
        idle_req  = '0;
        rr_model  = 0;
        prev_busy = 1'b0;
        drive();
        step();
        check("rst_busy", busy, 0);
        check("rst_grant_id", grant_id, 0);
        check("rst_ovf_err", ovf_err, 0);
        rst = 1'b0;
    endtask

    task automatic set_traffic(input int gap, input int ein, input int eout_gap, input int mrdy);
        gap_pct      = gap;
        ein_rdy_pct  = ein;
        eout_gap_pct = eout_gap;
        m_rdy_pct    = mrdy;
    endtask

    initial begin
        word_t pkt[$];
        int    n;
        s_tvalid = '0; s_tlast = '0; s_tdata = '0; m_tready = '0;
        eng_in_tready = 1'b0; eng_out_tvalid = 1'b0; eng_out_tlast = 1'b0; eng_out_tdata = '0;
        m_toggle = 1'b0; chk_mirror = 1'b0;
        set_traffic(0, 100, 0, 100);
        do_reset();

        // T1: {5,1,3} on req0 comes back as {1,3,5}
        pkt = {word_t'(5), word_t'(1), word_t'(3)};
        add_pkt(0, pkt);
        run_until_done("t1", 200);
        check("t1_eng_len", eng_len_log[$], 3);

        // T2: simultaneous requests after reset; req0's second packet waits for req1
        do_reset();
        add_rand_pkt(0, 4);
        add_rand_pkt(1, 3);
        add_rand_pkt(0, 2);
        run_until_done("t2", 300);
        check("t2_grant_count", grant_log.size(), 3);
        if (grant_log.size() == 3) begin
            check("t2_grant_0", grant_log[0], 0);
            check("t2_grant_1", grant_log[1], 1);
            check("t2_grant_2", grant_log[2], 0);
        end

        // T3: oversize packet truncated and flushed; exact MAX_LEN is legal
        set_traffic(0, 80, 0, 80);
        add_rand_pkt(1, MAX_LEN + 3);
        run_until_done("t3_ovf", 2000);
        check("t3_eng_len", eng_len_log[$], MAX_LEN);
        check("t3_ovf_err", ovf_err, exp_ovf);
        add_rand_pkt(0, MAX_LEN);
        run_until_done("t3_exact", 2000);
        check("t3_exact_eng_len", eng_len_log[$], MAX_LEN);
        check("t3_exact_ovf_err", ovf_err, exp_ovf);

        // T4: single-beat packet
        pkt = {word_t'(42)};
        add_pkt(2, pkt);
        run_until_done("t4", 200);
        check("t4_eng_len", eng_len_log[$], 1);
        check("t4_busy", busy, 0);
        check("t4_ovf_sticky", ovf_err, exp_ovf);

        // T5: consumer ready toggles every cycle during drain
        set_traffic(0, 100, 0, 100);
        m_toggle = 1'b1;
        chk_mirror = 1'b1;
        add_rand_pkt(0, 8);
        run_until_done("t5", 400);
        m_toggle = 1'b0;
        chk_mirror = 1'b0;

        // T6: reset in the middle of FEED, then a clean packet
        add_rand_pkt(2, 20);
        drive();
        n = 0;
        while (eng_buf.size() < 3 && n < 100) begin
            step();
            n++;
        end
        check("t6_reached_feed", eng_buf.size() >= 3, 1);
        do_reset();
        pkt = {word_t'(7), word_t'(2), word_t'(9), word_t'(4)};
        add_pkt(1, pkt);
        run_until_done("t6_after", 300);
        check("t6_eng_len", eng_len_log[$], 4);
        check("t6_ovf_err", ovf_err, 0);

        // Random traffic with stalls on every interface
        set_traffic(30, 70, 30, 70);
        for (int p = 0; p < 36; p++) begin
            if ($urandom_range(7) == 0) add_rand_pkt($urandom_range(N_REQ - 1), $urandom_range(MAX_LEN + 3, MAX_LEN - 2));
            else                        add_rand_pkt($urandom_range(N_REQ - 1), $urandom_range(12, 1));
        end
        run_until_done("rand", 40000);
        check("rand_ovf_err", ovf_err, exp_ovf);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
